// File: rtl/eth_fcs_pkg.sv
// Shared constants, FSM state type and the byte-wide CRC-32 step for the
// receive-side Ethernet FCS checker.
package eth_fcs_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } fcs_state_t;

    function automatic logic [31:0] crc32_byte_step(input logic [31:0] crc,
                                                    input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        // Taking wire bit 0 first is the same as shifting in the bit-reversed byte MSB first.
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[31] ^ data[i])
                c = {c[30:0], 1'b0} ^ CRC32_POLY;
            else
                c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_buf.sv
// 4-entry delay line that strips the trailing FCS: a byte leaves only once
// four newer bytes of the same frame have arrived.
module eth_rx_fcs_buf (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       accept,
    input  logic       start,
    input  logic       last,
    input  logic [7:0] data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof
);

    logic [7:0] dat [4];
    logic [3:0] vld;
    logic [3:0] sof;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            sof       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
                dat[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            if (accept) begin
                if (start) begin
                    // A new frame flushes whatever a previous, unterminated frame left behind.
                    vld    <= last ? 4'b0000 : 4'b0001;
                    sof    <= 4'b0001;
                    dat[0] <= data;
                end else begin
                    out_valid <= vld[3];
                    out_data  <= dat[3];
                    out_sof   <= sof[3];
                    out_eof   <= vld[3] & last;
                    vld       <= last ? 4'b0000 : {vld[2:0], 1'b1};
                    sof       <= {sof[2:0], 1'b0};
                    dat[3]    <= dat[2];
                    dat[2]    <= dat[1];
                    dat[1]    <= dat[0];
                    dat[0]    <= data;
                end
            end
        end
    end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: CRC-32 residue check, FCS strip and per-frame status.
// Optional FCS_STATS_EN adds good/crc-error/length-error frame counters.
module eth_rx_fcs_check
    import eth_fcs_pkg::*;
#(
    parameter int unsigned MIN_LEN = 64,
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef FCS_STATS_EN
    input  logic             stats_clr,
    output logic [31:0]      good_cnt,
    output logic [31:0]      crc_err_cnt,
    output logic [31:0]      len_err_cnt,
`endif
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_sof,
    output logic             out_eof,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             len_err,
    output logic             abort,
    output logic [CNT_W-1:0] frame_len
);

    fcs_state_t       state, state_next;
    logic [31:0]      crc, crc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [31:0]      len32;
    logic             in_frame, start, accept;

    assign in_frame = (state == RECV);
    assign start    = rx_valid & rx_sof;
    assign accept   = start | (rx_valid & in_frame);
    assign crc_next = crc32_byte_step(start ? CRC32_INIT : crc, rx_data);
    assign cnt_next = start ? CNT_W'(1) : ((&cnt) ? cnt : cnt + CNT_W'(1));
    assign len32    = 32'(cnt_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && !rx_eof) state_next = RECV;
            RECV:    if (rx_valid && rx_eof) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc        <= CRC32_INIT;
            cnt        <= '0;
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            len_err    <= 1'b0;
            abort      <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= 1'b0;
            if (accept) begin
                crc <= crc_next;
                cnt <= cnt_next;
            end
            // An abort reports the truncated frame; its own count is the old counter.
            if (start && in_frame) begin
                frame_done <= 1'b1;
                abort      <= 1'b1;
                crc_ok     <= 1'b0;
                len_err    <= 1'b1;
                frame_len  <= cnt;
            end else if (accept && rx_eof) begin
                frame_done <= 1'b1;
                abort      <= 1'b0;
                crc_ok     <= (crc_next == CRC32_RESIDUE);
                len_err    <= (len32 < MIN_LEN) || (len32 > MAX_LEN);
                frame_len  <= cnt_next;
            end
        end
    end

    eth_rx_fcs_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .accept    (accept),
        .start     (start),
        .last      (rx_eof),
        .data      (rx_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eof   (out_eof)
    );

`ifdef FCS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt    <= '0;
            crc_err_cnt <= '0;
            len_err_cnt <= '0;
        end else if (stats_clr) begin
            good_cnt    <= '0;
            crc_err_cnt <= '0;
            len_err_cnt <= '0;
        end else if (frame_done) begin
            if (crc_ok && !len_err) good_cnt <= good_cnt + 32'd1;
            if (!crc_ok && !abort)  crc_err_cnt <= crc_err_cnt + 32'd1;
            if (len_err)            len_err_cnt <= len_err_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check; expectations come from a reflected
// (LSB-first) CRC-32 reference model and a frame-level behavioural model.
module tb_eth_rx_fcs_check;

    localparam int unsigned MIN_LEN = 64;
    localparam int unsigned MAX_LEN = 100;
    localparam int unsigned CNT_W   = 12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             rx_sof = 1'b0;
    logic             rx_eof = 1'b0;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_sof;
    logic             out_eof;
    logic             frame_done;
    logic             crc_ok;
    logic             len_err;
    logic             abort;
    logic [CNT_W-1:0] frame_len;
`ifdef FCS_STATS_EN
    logic             stats_clr = 1'b0;
    logic [31:0]      good_cnt, crc_err_cnt, len_err_cnt;
`endif

    eth_rx_fcs_check #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FCS_STATS_EN
        .stats_clr  (stats_clr),
        .good_cnt   (good_cnt),
        .crc_err_cnt(crc_err_cnt),
        .len_err_cnt(len_err_cnt),
`endif
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .len_err    (len_err),
        .abort      (abort),
        .frame_len  (frame_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        bit          sof;
        bit          eof;
        int unsigned cyc;
    } exp_out_t;

    typedef struct {
        bit          ok;
        bit          le;
        bit          ab;
        int unsigned len;
        int unsigned cyc;
    } exp_st_t;

    exp_out_t    out_q[$];
    exp_st_t     st_q[$];
    logic [7:0]  fbuf[$];
    bit          open_f = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] refl_crc(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_good(input int n_total, output logic [7:0] f[$]);
        logic [31:0] fcs;
        f.delete();
        for (int i = 0; i < n_total - 4; i++) f.push_back(8'($urandom));
        fcs = ~refl_crc(f);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
    endtask

    // Drive one byte and record what the DUT must produce one cycle later.
    task automatic drive_byte(input logic [7:0] d, input bit sof, input bit eof);
        exp_st_t     s;
        exp_out_t    o;
        int unsigned n;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = d; rx_sof = sof; rx_eof = eof;
        if (sof) begin
            if (open_f) begin
                s.ok = 0; s.le = 1; s.ab = 1; s.len = fbuf.size(); s.cyc = cyc + 1;
                st_q.push_back(s);
            end
            open_f = 1'b1;
            fbuf.delete();
        end
        if (open_f) begin
            fbuf.push_back(d);
            n = fbuf.size();
            if (n >= 5) begin
                o.d = fbuf[n-5]; o.sof = (n == 5); o.eof = eof; o.cyc = cyc + 1;
                out_q.push_back(o);
            end
            if (eof) begin
                s.ok  = (refl_crc(fbuf) == 32'hDEBB20E3);
                s.le  = (n < MIN_LEN) || (n > MAX_LEN);
                s.ab  = 0;
                s.len = n;
                s.cyc = cyc + 1;
                st_q.push_back(s);
                open_f = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'($urandom);
        end
    endtask

    task automatic send_frame(input logic [7:0] f[$], input int gap_max, input bit with_eof);
        for (int i = 0; i < f.size(); i++) begin
            drive_byte(f[i], i == 0, with_eof && (i == f.size() - 1));
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        idle(1);
        while ((out_q.size() != 0 || st_q.size() != 0) && n < 20) begin
            idle(1);
            n++;
        end
        checks++;
        if (out_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes and %0d status pending, required 0", out_q.size(), st_q.size());
            out_q.delete();
            st_q.delete();
        end
    endtask

    always @(negedge clk) begin
        exp_out_t o;
        exp_st_t  s;
        if (rst_n) begin
            while (out_q.size() > 0 && out_q[0].cyc < cyc) begin
                o = out_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_out: byte %h due in cycle %0d not seen by cycle %0d", o.d, o.cyc, cyc);
            end
            while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
                s = st_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_done: frame_done due in cycle %0d not seen by cycle %0d", s.cyc, cyc);
            end
            if (out_valid) begin
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: out_valid with data %h in cycle %0d, required no output", out_data, cyc);
                end else begin
                    o = out_q.pop_front();
                    if ({out_data, out_sof, out_eof} !== {o.d, o.sof, o.eof} || o.cyc != cyc) begin
                        errors++;
                        $display("FAIL out_byte: got data=%h sof=%b eof=%b cyc=%0d, required data=%h sof=%b eof=%b cyc=%0d",
                                 out_data, out_sof, out_eof, cyc, o.d, o.sof, o.eof, o.cyc);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (st_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: frame_done in cycle %0d, required none", cyc);
                end else begin
                    s = st_q.pop_front();
                    if ({crc_ok, len_err, abort} !== {s.ok, s.le, s.ab} || frame_len !== CNT_W'(s.len) || s.cyc != cyc) begin
                        errors++;
                        $display("FAIL status: got ok=%b len_err=%b abort=%b len=%0d cyc=%0d, required ok=%b len_err=%b abort=%b len=%0d cyc=%0d",
                                 crc_ok, len_err, abort, frame_len, cyc, s.ok, s.le, s.ab, s.len, s.cyc);
                    end
                end
            end
        end
    end

    task automatic check_outputs_zero(input string name);
        logic [31:0] other;
        other = '0;
`ifdef FCS_STATS_EN
        other = good_cnt | crc_err_cnt | len_err_cnt;
`endif
        checks++;
        if ({out_valid, out_data, out_sof, out_eof, frame_done, crc_ok, len_err, abort, frame_len} !== '0 || other !== '0) begin
            errors++;
            $display("FAIL %s: outputs valid=%b data=%h done=%b ok=%b le=%b ab=%b len=%0d stats_or=%h, required all 0",
                     name, out_valid, out_data, frame_done, crc_ok, len_err, abort, frame_len, other);
        end
    endtask

    task automatic check_held(input string name, input bit ok, input bit le, input bit ab, input int unsigned len);
        checks++;
        if ({crc_ok, len_err, abort} !== {ok, le, ab} || frame_len !== CNT_W'(len)) begin
            errors++;
            $display("FAIL %s: held ok=%b len_err=%b abort=%b len=%0d, required ok=%b len_err=%b abort=%b len=%0d",
                     name, crc_ok, len_err, abort, frame_len, ok, le, ab, len);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        check_outputs_zero("reset_state");
        @(posedge clk); #2 rst_n = 1'b1;
        idle(2);
        check_outputs_zero("after_reset_release");
    endtask

    task automatic test_good_frame();
        logic [7:0] f[$];
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(f, 0, 1'b1);
        drain();
        check_held("known_vector", 1'b1, 1'b1, 1'b0, 13);
    endtask

    task automatic test_bad_crc();
        logic [7:0] f[$];
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCA};
        send_frame(f, 0, 1'b1);
        drain();
        check_held("bad_fcs", 1'b0, 1'b1, 1'b0, 13);
    endtask

    task automatic test_gaps_and_min_len();
        logic [7:0] f[$];
        build_good(64, f);
        send_frame(f, 3, 1'b1);
        drain();
        check_held("min_len_64", 1'b1, 1'b0, 1'b0, 64);
        build_good(63, f);
        send_frame(f, 3, 1'b1);
        drain();
        check_held("below_min_63", 1'b1, 1'b1, 1'b0, 63);
    endtask

    task automatic test_max_len();
        logic [7:0] f[$];
        build_good(MAX_LEN, f);
        send_frame(f, 0, 1'b1);
        drain();
        check_held("max_len", 1'b1, 1'b0, 1'b0, MAX_LEN);
        build_good(MAX_LEN + 1, f);
        send_frame(f, 1, 1'b1);
        drain();
        check_held("above_max", 1'b1, 1'b1, 1'b0, MAX_LEN + 1);
    endtask

    task automatic test_abort();
        logic [7:0] a[$];
        logic [7:0] b[$];
        build_good(70, a);
        for (int i = 0; i < 20; i++) drive_byte(a[i], i == 0, 1'b0);
        build_good(66, b);
        send_frame(b, 2, 1'b1);
        drain();
        check_held("after_abort", 1'b1, 1'b0, 1'b0, 66);
    endtask

    task automatic test_short_frames();
        drive_byte(8'hAA, 1'b0, 1'b0);
        drive_byte(8'h55, 1'b0, 1'b1);
        send_frame('{8'h01, 8'h02, 8'h03}, 0, 1'b1);
        drain();
        check_held("three_byte", 1'b0, 1'b1, 1'b0, 3);
        drive_byte(8'h5A, 1'b1, 1'b1);
        drain();
        check_held("single_byte", 1'b0, 1'b1, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] f[$];
        logic [7:0] g[$];
        build_good(64, f);
        build_good(80, g);
        g[40] = g[40] ^ 8'h10;
        send_frame(f, 0, 1'b1);
        send_frame(g, 0, 1'b1);
        drain();
        check_held("back_to_back", 1'b0, 1'b0, 1'b0, 80);
    endtask

    task automatic test_mid_reset();
        logic [7:0] f[$];
        build_good(64, f);
        for (int i = 0; i < 10; i++) drive_byte(f[i], i == 0, 1'b0);
        idle(2);
        @(posedge clk); #2 rst_n = 1'b0;
        open_f = 1'b0;
        fbuf.delete();
        idle(1);
        check_outputs_zero("mid_frame_reset");
        @(posedge clk); #2 rst_n = 1'b1;
        idle(2);
        build_good(64, f);
        send_frame(f, 1, 1'b1);
        drain();
        check_held("after_mid_reset", 1'b1, 1'b0, 1'b0, 64);
`ifdef FCS_STATS_EN
        checks++;
        if (good_cnt !== 32'd1 || crc_err_cnt !== 32'd0 || len_err_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_after_reset: good=%0d crc_err=%0d len_err=%0d, required 1 0 0",
                     good_cnt, crc_err_cnt, len_err_cnt);
        end
        @(negedge clk); stats_clr = 1'b1;
        @(negedge clk); stats_clr = 1'b0;
        checks++;
        if (good_cnt !== 32'd0) begin
            errors++;
            $display("FAIL stats_clr: good=%0d, required 0", good_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_gaps_and_min_len();
        test_max_len();
        test_abort();
        test_short_frames();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- Receive-side Ethernet FCS checker. Sits between the GMII/RGMII byte receiver (preamble/SFD already removed) and the UDP/IP RX parser.
- Runs the CRC-32 over every frame byte including the 4-byte FCS, then checks the residue.
- Forwards the payload with the FCS stripped, using a 4-byte delay buffer.
- Reports per-frame status in the same cycle as the last forwarded byte.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included.
- MAX_LEN, 1518, maximum legal frame length in bytes, FCS included.
- CNT_W, 12, width of the byte counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- rx_valid  in  1  input byte strobe.
- rx_data  in  8  input byte, wire order.
- rx_sof  in  1  first byte of frame; qualified by rx_valid.
- rx_eof  in  1  last byte of frame; qualified by rx_valid; may coincide with rx_sof.
- out_valid  out  1  payload byte strobe.
- out_data  out  8  payload byte.
- out_sof  out  1  first payload byte.
- out_eof  out  1  last payload byte.
- frame_done  out  1  one-cycle status pulse.
- crc_ok  out  1  residue matched; valid while frame_done is high.
- len_err  out  1  length outside [MIN_LEN, MAX_LEN]; valid while frame_done is high.
- abort  out  1  frame ended by a new rx_sof with no rx_eof; valid while frame_done is high.
- frame_len  out  CNT_W  byte count of the frame, FCS included; valid while frame_done is high.

Interface and reset:
- Reset rst_n, asynchronous, active-low; clock clk.
- Reset values: every output is 0. The CRC register resets to 32'hFFFFFFFF; the counter, buffer valid bits and FSM state all reset to 0 / IDLE.

Behaviour:
- CRC definition:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - Each input byte is bit-reversed before the update; the register is kept in normal (non-reflected) order.
  - After all bytes including the FCS, a good frame leaves the residue 32'hC704DD7B. crc_ok = (crc_next == 32'hC704DD7B), evaluated on the rx_eof byte.
- FSM states: IDLE and RECV.
  - IDLE, rx_valid&rx_sof: CRC is loaded with the update of 0xFFFFFFFF by this byte, counter=1, byte enters the buffer, go to RECV. If rx_eof is also set, finish immediately (see finish).
  - IDLE, rx_valid without rx_sof: byte is ignored; no output.
  - RECV, rx_valid: CRC update, counter+1 (saturating), byte shifts into the buffer.
  - RECV, rx_eof: finish, go to IDLE.
  - RECV, rx_sof: abort. frame_done=1, abort=1, crc_ok=0, len_err=1. The buffer is flushed and the earlier partial frame gets no out_eof. The new byte is handled exactly as in IDLE, and the FSM stays in RECV.
- Delay buffer: 4-entry shift register, each entry with a valid bit.
  - Accepting input byte k (k ≥ 4, 0-based) emits byte k-4 on the next cycle: out_valid=1.
  - out_sof is set on the first emitted byte (k-4 = 0).
  - out_eof = the rx_eof of the accepting cycle.
  - On finish, the 4 buffered bytes are the FCS and are discarded; all valid bits clear.
  - Frames of ≤4 bytes produce no payload output, but frame_done still pulses.
- Finish, registered one cycle after the rx_eof byte and coincident with out_eof:
  - frame_done=1.
  - crc_ok as defined above.
  - len_err = (count < MIN_LEN) or (count > MAX_LEN).
  - frame_len = count.
  - abort=0.
- Latency: fixed. Output byte k appears 1 cycle after input byte k+4. Gaps in rx_valid pass through; the buffer holds its contents.
- Status outputs other than frame_done are held until the next frame_done.
- rst_n asserted mid-frame: everything clears; no frame_done is issued.

Optional Feature:
- Macro FCS_STATS_EN.
- When defined, add outputs good_cnt[31:0], crc_err_cnt[31:0] and len_err_cnt[31:0], plus input stats_clr.
  - Counters increment on frame_done according to: crc_ok&!len_err, !crc_ok, len_err. Abort counts as a length error only.
  - Counters wrap at 2^32.
  - stats_clr is synchronous and takes priority over an increment in the same cycle.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package eth_fcs_pkg holds:
  - CRC32_POLY = 32'h04C11DB7.
  - CRC32_INIT = 32'hFFFFFFFF.
  - CRC32_RESIDUE = 32'hC704DD7B.
  - Function crc32_byte_step(crc, byte), the combinational next-value equations.
  - FSM state typedef.
- Sub-module eth_rx_fcs_buf: the 4-entry delay/strip buffer with valid bits, sof tracking and flush.

Test Plan:
- Frame of 9 bytes 31..39 followed by FCS 26 39 F4 CB, with MIN_LEN=5 → out bytes 31..39 (out_sof on 31, out_eof on 39), frame_done, crc_ok=1, len_err=0, frame_len=13.
- Same frame with last FCS byte CB changed to CA → payload still forwarded, crc_ok=0.
- 64-byte frame with a correct FCS, including rx_valid gaps of 1–3 cycles → 60 output bytes in order, crc_ok=1; frame_done at MIN_LEN=64 gives len_err=0. A 63-byte frame gives len_err=1.
- rx_sof again at byte 20 without rx_eof → abort=1 pulse; no out_eof for the first frame; the second frame checks normally.
- 3-byte frame and a sof&eof single byte → no out_valid; frame_done with len_err=1, frame_len=3 and 1 respectively.
- rst_n pulsed at byte 10 → all outputs 0, no frame_done. The next good frame passes with crc_ok=1. With FCS_STATS_EN, good_cnt=1.
